multicycle_sequencer: RTL and testbench
=======================================

// Module: multicycle_sequencer
// PURPOSE
//  Multi-cycle successor to the single-cycle `controller`: an FSM that steps each instruction
//  through FETCH/DECODE/EXEC/MEM/WB with req/ack handshakes to variable-latency instruction and
//  data memories.
//  Static mux/ALU selects still come from the combinational `controller`; this block
//  phase-qualifies every state-changing enable (PC, IR, regfile, dmem), counts retirements and
//  traps on illegal decode or memory timeout.
// PARAMETERS
//  NUM_INSTR    32  width of one-hot decoded_instr (index map: 16 jr, 23 lw, 24 sw, 25 beq, 26 bne, 29 j, 30 jal; others ALU)
//  MEM_TIMEOUT  64  max cycles req may wait for ack before trap; 0 disables watchdog
//  RETIRE_W     32  width of retire_count
// PORTS
//  clk            in   1          system clock, rising edge
//  rst            in   1          synchronous reset, active high
//  decoded_instr  in   NUM_INSTR  one-hot decoded current instruction (valid from DECODE onward)
//  zero_signal    in   1          ALU zero flag, valid in EXEC
//  dec_regfile_w  in   1          regfile write request from combinational `controller`
//  imem_req       out  1          instruction fetch request
//  imem_ack       in   1          fetch data valid this cycle
//  dmem_req       out  1          data access request
//  dmem_we        out  1          1 = store, 0 = load; valid while dmem_req
//  dmem_ack       in   1          data access complete this cycle
//  ir_w           out  1          load instruction register
//  pc_w           out  1          commit next PC (PC+4, branch or jump target via `controller` mux)
//  rf_w           out  1          regfile write enable (phase-qualified)
//  branch_taken   out  1          beq&zero | bne&~zero | j | jal | jr; valid with pc_w
//  retired        out  1          one-cycle pulse per completed instruction
//  retire_count   out  RETIRE_W   retired-instruction counter, wraps modulo 2^RETIRE_W
//  trap           out  1          sticky error; cleared only by rst
//  trap_cause     out  2          01 illegal decode, 10 imem timeout, 11 dmem timeout, 00 none
// BEHAVIOUR
//  - rst: state=FETCH, wait counter=0, retire_count=0, trap=0, trap_cause=00; every output 0 while rst high.
//  - Outputs are Moore decodes of state plus same-cycle ack/zero_signal; no other combinational paths.
//  - FETCH: imem_req=1 held until imem_ack; on ack cycle ir_w=1, next DECODE. Ack while req=0 ignored.
//  - DECODE (1 cycle): popcount(decoded_instr)!=1 -> TRAP, cause 01; else -> EXEC.
//  - EXEC (1 cycle):
//    * jr/j/jal/beq/bne: pc_w=1, branch_taken per formula, retired=1; jal also rf_w=1; next FETCH.
//    * lw/sw: next MEM. Any other instruction: next WB.
//  - MEM: dmem_req=1, dmem_we=sw, held until dmem_ack.
//    * On ack, sw: pc_w=1, retired=1, next FETCH.
//    * On ack, lw: next WB.
//  - WB (1 cycle): rf_w=dec_regfile_w, pc_w=1, retired=1; next FETCH.
//  - pc_w and retired pulse exactly once per instruction, in the same cycle; rf_w never outside EXEC(jal)/WB.
//  - Latency with zero-wait ack (ack in first req cycle): branch/jump 3, ALU 4, sw 4, lw 5 cycles.
//    Each memory wait cycle adds 1.
//  - Watchdog: counter resets on entering FETCH/MEM and increments each req cycle without ack.
//    Reaching MEM_TIMEOUT -> TRAP, cause 10/11. Ack in the same cycle the limit is reached wins (no trap).
//  - TRAP: all req/enable outputs 0, trap=1, FSM frozen until rst. Counters hold.
//  - retire_count increments on retired; at 2^RETIRE_W-1 it wraps to 0.
//  - rst mid-handshake: req dropped immediately next cycle, ack during reset ignored, restart at FETCH.
// TESTING
//  1 add, acks zero-wait -> ir_w @c1, WB @c4 with rf_w=1,pc_w=1,retired=1; retire_count=1.
//  2 lw, dmem_ack after 3 wait cycles -> dmem_req high 4 cycles, dmem_we=0, rf_w @WB, total 8 cycles.
//  3 beq zero=1 then bne zero=1 -> branch_taken 1 then 0; each pc_w once, rf_w never asserted.
//  4 decoded_instr=0 (and =0x3 separately) -> trap=1, trap_cause=01 after DECODE; outputs 0 until rst.
//  5 MEM_TIMEOUT=4, imem_ack never -> trap_cause=10 after 4 req cycles; ack on 4th cycle -> no trap.
//  6 RETIRE_W=3, 9 instructions -> retire_count 7 -> 0 -> 1; rst during MEM -> dmem_req=0, restart FETCH.

Source files
------------

// File: rtl/multicycle_sequencer_if.sv
// Handshake bundle between the sequencer and its instruction/data memories.
// Latency: none (wires only).
// Backpressure: each req is held until its ack; an ack is only honoured while its req is high.
//   imem_req/imem_ack : instruction fetch request and fetch-data-valid strobe
//   dmem_req/dmem_we  : data access request, 1 = store / 0 = load while dmem_req
//   dmem_ack          : data access complete strobe
interface multicycle_sequencer_if;
  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;

  modport master (output imem_req, dmem_req, dmem_we, input imem_ack, dmem_ack);
  modport slave  (input imem_req, dmem_req, dmem_we, output imem_ack, dmem_ack);
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with phase-qualified
// PC/IR/regfile/dmem enables, retirement counting and a sticky trap.
// Latency with zero-wait acks: branch/jump 3, ALU 4, sw 4, lw 5 cycles; +1 per memory wait cycle.
// Backpressure: req held until ack; a watchdog traps after MEM_TIMEOUT unacked req cycles.
// Ports:
//   clk, rst         : clock, synchronous active-high reset (all outputs forced 0 while high)
//   decoded_instr    : one-hot decoded instruction, valid from DECODE onward
//   zero_signal      : ALU zero flag (EXEC), dec_regfile_w: regfile write request (WB)
//   mem              : imem/dmem req/ack handshakes (master side)
//   ir_w, pc_w, rf_w : IR load, PC commit, regfile write enables
//   branch_taken     : branch/jump outcome, valid with pc_w
//   retired          : one-cycle pulse per completed instruction, retire_count counts them
//   trap, trap_cause : sticky error, 01 illegal decode, 10 imem timeout, 11 dmem timeout
module multicycle_sequencer #(
  parameter int NUM_INSTR   = 32,
  parameter int MEM_TIMEOUT = 64,
  parameter int RETIRE_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_INSTR-1:0] decoded_instr,
  input  logic                 zero_signal,
  input  logic                 dec_regfile_w,
  multicycle_sequencer_if.master mem,
  output logic                 ir_w,
  output logic                 pc_w,
  output logic                 rf_w,
  output logic                 branch_taken,
  output logic                 retired,
  output logic [RETIRE_W-1:0]  retire_count,
  output logic                 trap,
  output logic [1:0]           trap_cause
);

  localparam int IDX_JR  = 16;
  localparam int IDX_LW  = 23;
  localparam int IDX_SW  = 24;
  localparam int IDX_BEQ = 25;
  localparam int IDX_BNE = 26;
  localparam int IDX_J   = 29;
  localparam int IDX_JAL = 30;

  // Wait counter only has to hold 0..MEM_TIMEOUT-1; the limit is detected one step early.
  localparam int            WW          = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit            WDOG_EN     = (MEM_TIMEOUT > 0);
  localparam int            WAIT_LAST_I = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam logic [WW-1:0] WAIT_LAST   = WW'(WAIT_LAST_I);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  state_t              state_q, state_d;
  logic [WW-1:0]       wait_q, wait_d;
  logic [RETIRE_W-1:0] cnt_q, cnt_d;
  logic                trap_q, trap_d;
  logic [1:0]          cause_q, cause_d;

  logic o_imem_req, o_dmem_req, o_dmem_we;
  logic o_ir_w, o_pc_w, o_rf_w, o_bt, o_retired;

  logic is_jr, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_branch, is_mem;

  assign is_jr     = decoded_instr[IDX_JR];
  assign is_lw     = decoded_instr[IDX_LW];
  assign is_sw     = decoded_instr[IDX_SW];
  assign is_beq    = decoded_instr[IDX_BEQ];
  assign is_bne    = decoded_instr[IDX_BNE];
  assign is_j      = decoded_instr[IDX_J];
  assign is_jal    = decoded_instr[IDX_JAL];
  assign is_branch = is_jr | is_j | is_jal | is_beq | is_bne;
  assign is_mem    = is_lw | is_sw;

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    trap_d     = trap_q;
    cause_d    = cause_q;
    o_imem_req = 1'b0;
    o_dmem_req = 1'b0;
    o_dmem_we  = 1'b0;
    o_ir_w     = 1'b0;
    o_pc_w     = 1'b0;
    o_rf_w     = 1'b0;
    o_bt       = 1'b0;
    o_retired  = 1'b0;

    case (state_q)
      S_FETCH: begin
        o_imem_req = 1'b1;
        if (mem.imem_ack) begin
          // Ack on the limit cycle still wins over the watchdog.
          o_ir_w  = 1'b1;
          state_d = S_DECODE;
        end else if (WDOG_EN && wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = 2'b10;
        end else if (WDOG_EN) begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DECODE: begin
        if ($countones(decoded_instr) != 1) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = 2'b01;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_branch) begin
          o_pc_w    = 1'b1;
          o_retired = 1'b1;
          o_rf_w    = is_jal;
          o_bt      = (is_beq & zero_signal) | (is_bne & ~zero_signal) | is_j | is_jal | is_jr;
          state_d   = S_FETCH;
          wait_d    = '0;
        end else if (is_mem) begin
          state_d = S_MEM;
          wait_d  = '0;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        o_dmem_req = 1'b1;
        o_dmem_we  = is_sw;
        if (mem.dmem_ack) begin
          if (is_sw) begin
            o_pc_w    = 1'b1;
            o_retired = 1'b1;
            state_d   = S_FETCH;
            wait_d    = '0;
          end else begin
            state_d = S_WB;
          end
        end else if (WDOG_EN && wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = 2'b11;
        end else if (WDOG_EN) begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB: begin
        o_rf_w    = dec_regfile_w;
        o_pc_w    = 1'b1;
        o_retired = 1'b1;
        state_d   = S_FETCH;
        wait_d    = '0;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
        wait_d  = '0;
      end
    endcase

    cnt_d = cnt_q + RETIRE_W'(o_retired);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      cnt_q   <= '0;
      trap_q  <= 1'b0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      trap_q  <= trap_d;
      cause_q <= cause_d;
    end
  end

  // Reset masks every output in the same cycle so a mid-handshake reset drops req at once.
  assign mem.imem_req  = o_imem_req & ~rst;
  assign mem.dmem_req  = o_dmem_req & ~rst;
  assign mem.dmem_we   = o_dmem_we & ~rst;
  assign ir_w          = o_ir_w & ~rst;
  assign pc_w          = o_pc_w & ~rst;
  assign rf_w          = o_rf_w & ~rst;
  assign branch_taken  = o_bt & ~rst;
  assign retired       = o_retired & ~rst;
  assign retire_count  = rst ? '0 : cnt_q;
  assign trap          = trap_q & ~rst;
  assign trap_cause    = rst ? 2'b00 : cause_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized scoreboard bench for multicycle_sequencer (MEM_TIMEOUT=4, RETIRE_W=3).
// Latency: n/a. Backpressure: bench memories insert 0..3 wait cycles per access.
module tb_multicycle_sequencer;
  localparam int NI = 32;
  localparam int MT = 4;
  localparam int RW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NI-1:0] decoded_instr = '0;
  logic          zero_signal = 1'b0;
  logic          dec_regfile_w = 1'b0;
  logic          ir_w, pc_w, rf_w, branch_taken, retired, trap;
  logic [RW-1:0] retire_count;
  logic [1:0]    trap_cause;
  logic [RW+10:0] outvec;

  multicycle_sequencer_if mif();

  multicycle_sequencer #(.NUM_INSTR(NI), .MEM_TIMEOUT(MT), .RETIRE_W(RW)) dut (
    .clk(clk), .rst(rst), .decoded_instr(decoded_instr), .zero_signal(zero_signal),
    .dec_regfile_w(dec_regfile_w), .mem(mif), .ir_w(ir_w), .pc_w(pc_w), .rf_w(rf_w),
    .branch_taken(branch_taken), .retired(retired), .retire_count(retire_count),
    .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  assign outvec = {mif.imem_req, mif.dmem_req, mif.dmem_we, ir_w, pc_w, rf_w,
                   branch_taken, retired, retire_count, trap, trap_cause};

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            lat_end;
    bit            bt;
    bit            rfw;
    int            ireq;
    int            dreq;
    bit            we;
    logic [RW-1:0] cnt_before;
  } exp_t;

  exp_t          sb[$];
  logic [RW-1:0] ref_cnt = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: per-instruction req-cycle tallies, popped and compared on each retirement.
  initial begin
    int   ireq;
    int   dreq;
    bit   we;
    exp_t e;
    ireq = 0; dreq = 0; we = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ireq = 0; dreq = 0; we = 0;
      end else begin
        ireq += int'(mif.imem_req);
        dreq += int'(mif.dmem_req);
        if (mif.dmem_req && mif.dmem_we) we = 1;
        check("pc_w_eq_retired", pc_w, retired);
        if (rf_w) check("rf_w_outside_retire", retired, 1);
        if (retired) begin
          check("sb_nonempty_on_retire", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("retire_cycle", cyc, e.lat_end);
            check("branch_taken", branch_taken, e.bt);
            check("rf_w", rf_w, e.rfw);
            check("imem_req_cycles", ireq, e.ireq);
            check("dmem_req_cycles", dreq, e.dreq);
            check("dmem_we", we, e.we);
            check("retire_count", retire_count, e.cnt_before);
          end
          ireq = 0; dreq = 0; we = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction; entered and left at posedge+1 of a FETCH cycle.
  task automatic run_instr(input int idx, input int wi, input int wd, input bit z, input bit rfw);
    bit   is_br, is_mem, is_sw;
    int   lat;
    exp_t e;
    is_br  = (idx == 16) || (idx == 25) || (idx == 26) || (idx == 29) || (idx == 30);
    is_mem = (idx == 23) || (idx == 24);
    is_sw  = (idx == 24);
    lat    = is_br ? 3 : (idx == 23) ? 5 + wi + wd : 4 + wi + (is_mem ? wd : 0);
    if (is_br) lat = 3 + wi;
    decoded_instr = NI'(1) << idx;
    zero_signal   = z;
    dec_regfile_w = rfw;
    e.lat_end    = cyc + lat - 1;
    e.bt         = (idx == 25 && z) || (idx == 26 && !z) || idx == 16 || idx == 29 || idx == 30;
    e.rfw        = (idx == 30) || (!is_br && !is_sw && rfw);
    e.ireq       = wi + 1;
    e.dreq       = is_mem ? wd + 1 : 0;
    e.we         = is_sw;
    e.cnt_before = ref_cnt;
    ref_cnt      = ref_cnt + 1'b1;
    sb.push_back(e);
    for (int i = 0; i < lat; i++) begin
      if (i > 0) step();
      // Acks outside their request window are random noise the DUT must ignore.
      mif.imem_ack = (i == wi) ? 1'b1 : (i > wi) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (is_mem) mif.dmem_ack = (i == wi + 3 + wd) ? 1'b1 : (i < wi + 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      else        mif.dmem_ack = 1'($urandom_range(0, 1));
    end
    step();
    mif.imem_ack = 1'b0;
    mif.dmem_ack = 1'b0;
    check("sb_drained", sb.size(), 0);
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    mif.imem_ack = 1'b1;
    mif.dmem_ack = 1'b1;
    #1;
    check("outputs_zero_entering_reset", outvec, 0);
    step();
    step();
    check("outputs_zero_in_reset", outvec, 0);
    rst = 1'b0;
    mif.imem_ack = 1'b0;
    mif.dmem_ack = 1'b0;
    sb.delete();
    ref_cnt = '0;
    #1;
    check("post_reset_count", retire_count, 0);
    check("post_reset_trap", {trap, trap_cause}, 0);
    check("post_reset_fetch_req", {mif.imem_req, mif.dmem_req}, 2'b10);
  endtask

  task automatic trap_hold(input string name, input logic [1:0] cause, input logic [RW-1:0] cnt);
    for (int k = 0; k < 3; k++) begin
      mif.imem_ack = 1'b1;
      mif.dmem_ack = 1'b1;
      #1;
      check({name, "_trap"}, {trap, trap_cause}, {1'b1, cause});
      check({name, "_quiet"}, outvec[RW+10:RW+3], 0);
      check({name, "_count_hold"}, retire_count, cnt);
      step();
    end
    mif.imem_ack = 1'b0;
    mif.dmem_ack = 1'b0;
  endtask

  initial begin
    int kinds[8] = '{0, 16, 23, 24, 25, 26, 29, 30};
    logic [NI-1:0] bad [2] = '{32'h0, 32'h3};
    mif.imem_ack = 1'b0;
    mif.dmem_ack = 1'b0;
    #2;
    check("outputs_zero_at_start", outvec, 0);
    do_reset();

    // Directed: add, lw with 3 data waits, beq/bne with zero=1, fetch ack on the limit cycle.
    run_instr(0, 0, 0, 1'b0, 1'b1);
    run_instr(23, 0, 3, 1'b0, 1'b1);
    run_instr(25, 0, 0, 1'b1, 1'b0);
    run_instr(26, 0, 0, 1'b1, 1'b0);
    run_instr(30, 3, 0, 1'b0, 1'b0);
    run_instr(24, 1, 3, 1'b0, 1'b1);

    // Illegal decodes.
    foreach (bad[b]) begin
      do_reset();
      decoded_instr = bad[b];
      mif.imem_ack = 1'b1;
      step();
      mif.imem_ack = 1'b0;
      #1;
      check("decode_no_early_trap", trap, 0);
      step();
      trap_hold("illegal_decode", 2'b01, '0);
    end

    // Instruction fetch timeout.
    do_reset();
    for (int k = 0; k < MT; k++) begin
      check("imem_wait_req", mif.imem_req, 1);
      step();
    end
    trap_hold("imem_timeout", 2'b10, '0);

    // Data timeout after two retirements (count must freeze at 2).
    do_reset();
    run_instr(29, 0, 0, 1'b0, 1'b0);
    run_instr(3, 2, 0, 1'b0, 1'b1);
    decoded_instr = NI'(1) << 23;
    mif.imem_ack = 1'b1;
    step();
    mif.imem_ack = 1'b0;
    step();
    step();
    for (int k = 0; k < MT; k++) begin
      check("dmem_wait_req", mif.dmem_req, 1);
      step();
    end
    trap_hold("dmem_timeout", 2'b11, 3'd2);

    // Reset in the middle of a data access.
    do_reset();
    decoded_instr = NI'(1) << 24;
    mif.imem_ack = 1'b1;
    step();
    mif.imem_ack = 1'b0;
    step();
    step();
    step();
    check("mem_before_reset", {mif.dmem_req, mif.dmem_we}, 2'b11);
    do_reset();

    // Randomized stream; also walks the 3-bit counter through several wraps.
    for (int n = 0; n < 40; n++) begin
      int k;
      int idx;
      k   = int'($urandom_range(0, 7));
      idx = (kinds[k] == 0) ? int'($urandom_range(0, 15)) : kinds[k];
      run_instr(idx, int'($urandom_range(0, MT - 1)), int'($urandom_range(0, MT - 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    #1;
    check("final_retire_count", retire_count, ref_cnt);
    check("final_no_trap", trap, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
